// File: rtl/ro_freq_window_counter.sv
// Counts synchronized rising edges of a divided ring-oscillator over a programmable CLK window.
// Optional RO_FREQ_AVG_EN: each result is the truncated mean of four back-to-back sub-windows.
module ro_freq_window_counter #(
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ro_div_i,
    input  logic             enable_i,
    input  logic [WIN_W-1:0] window_cycles_i,
    output logic [CNT_W-1:0] counter_o,
    output logic             count_done_o,
    output logic             overflow_o
);
    typedef enum logic [2:0] {IDLE, ARM, COUNT, DONE, GAP} state_e;

    localparam logic [WIN_W-1:0] ARM_LAST = WIN_W'(SYNC_STAGES);
    localparam logic [WIN_W-1:0] GAP_LAST = WIN_W'(GAP_CYCLES - 1);

    state_e               state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 sync_qq;
    logic [WIN_W-1:0]     tmr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_q;
    logic                 edge_det;
    logic                 tmr_last;
    logic [CNT_W-1:0]     cnt_d;
    logic                 ovf_d;
    logic [WIN_W-1:0]     win_m1;

    // Synchronizer plus one extra flop so edge detection only sees settled values
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            sync_qq <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_div_i};
            sync_qq <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_qq;
    assign tmr_last = (tmr_q == '0);
    assign cnt_d    = (edge_det && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    assign ovf_d    = ovf_q | (edge_det & (&cnt_q));
    assign win_m1   = (window_cycles_i == '0) ? '0 : window_cycles_i - 1'b1;

`ifdef RO_FREQ_AVG_EN
    logic [WIN_W-1:0] win_q;
    logic [1:0]       sub_q;
    logic [CNT_W+1:0] acc_q;
    logic [CNT_W+1:0] acc_sum;

    assign acc_sum = acc_q + {2'b00, cnt_d};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            counter_o    <= '0;
            overflow_o   <= 1'b0;
            count_done_o <= 1'b0;
`ifdef RO_FREQ_AVG_EN
            win_q        <= '0;
            sub_q        <= '0;
            acc_q        <= '0;
`endif
        end else begin
            count_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= ARM;
                        tmr_q   <= ARM_LAST;
                    end
                end
                ARM: begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
`ifdef RO_FREQ_AVG_EN
                    sub_q <= '0;
                    acc_q <= '0;
`endif
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (tmr_last) begin
                        state_q <= COUNT;
                        tmr_q   <= win_m1;
`ifdef RO_FREQ_AVG_EN
                        win_q   <= win_m1;
`endif
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                COUNT: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (!tmr_last) begin
                        tmr_q <= tmr_q - 1'b1;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                    end else begin
`ifdef RO_FREQ_AVG_EN
                        // ovf_q is not cleared between sub-windows, so it ORs their flags
                        if (sub_q != 2'd3) begin
                            sub_q <= sub_q + 1'b1;
                            acc_q <= acc_sum;
                            cnt_q <= '0;
                            ovf_q <= ovf_d;
                            tmr_q <= win_q;
                        end else begin
                            counter_o    <= acc_sum[CNT_W+1:2];
                            overflow_o   <= ovf_d;
                            count_done_o <= 1'b1;
                            state_q      <= DONE;
                        end
`else
                        counter_o    <= cnt_d;
                        overflow_o   <= ovf_d;
                        count_done_o <= 1'b1;
                        state_q      <= DONE;
`endif
                    end
                end
                DONE: begin
                    state_q <= GAP;
                    tmr_q   <= GAP_LAST;
                end
                GAP: begin
                    if (tmr_last) begin
                        state_q <= enable_i ? ARM : IDLE;
                        tmr_q   <= ARM_LAST;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_freq_window_counter.sv
// Bench for ro_freq_window_counter: sequential measurement model plus directed and random stimulus.
module tb_ro_freq_window_counter;
    localparam int S    = 2;
    localparam int GAP  = 4;
    localparam int MAXC = 255;
`ifdef RO_FREQ_AVG_EN
    localparam int NSUB = 4;
`else
    localparam int NSUB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, ro, en;
    logic [15:0] win;
    logic [7:0]  counter;
    logic        done, ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_on = 0;
    int ro_mode = 0;
    int ro_per = 8;
    int ro_ph = 0;

    ro_freq_window_counter dut (
        .clk_i(clk), .rst_i(rst), .ro_div_i(ro), .enable_i(en),
        .window_cycles_i(win), .counter_o(counter), .count_done_o(done), .overflow_o(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // RO source: constant 0, square wave of ro_per cycles, or random bits
    always @(negedge clk) begin
        case (ro_mode)
            0: ro = 1'b0;
            1: begin
                ro_ph = (ro_ph + 1) % ro_per;
                ro    = (ro_ph < ro_per / 2);
            end
            default: ro = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural model: walks one measurement at a time in plain procedural code
    bit hq[$];
    bit m_rst, m_en, m_edge;
    int m_win;
    int exp_cnt = 0;
    bit exp_ovf = 0, exp_done = 0;

    task automatic tick();
        @(posedge clk);
        m_rst  = rst;
        m_en   = en;
        m_win  = int'(win);
        m_edge = hq[S-1] && !hq[S];
        exp_done = 0;
        if (rst) begin
            hq.delete();
            for (int i = 0; i <= S; i++) hq.push_back(1'b0);
            exp_cnt = 0;
            exp_ovf = 0;
        end else begin
            hq.push_front(ro);
            void'(hq.pop_back());
        end
    endtask

    task automatic run_meas();
        int lw, sub, tot;
        bit of;
        lw = 1;
        forever begin
            for (int i = 0; i <= S; i++) begin
                tick();
                if (m_rst || !m_en) return;
                lw = (m_win == 0) ? 1 : m_win;
            end
            tot = 0;
            of  = 0;
            for (int k = 0; k < NSUB; k++) begin
                sub = 0;
                for (int i = 0; i < lw; i++) begin
                    tick();
                    if (m_rst || !m_en) return;
                    sub += int'(m_edge);
                end
                if (sub > MAXC) begin
                    of  = 1;
                    sub = MAXC;
                end
                tot += sub;
            end
            exp_cnt  = tot / NSUB;
            exp_ovf  = of;
            exp_done = 1;
            for (int i = 0; i <= GAP; i++) begin
                tick();
                if (m_rst) return;
            end
            if (!m_en) return;
        end
    endtask

    initial begin : model
        for (int i = 0; i <= S; i++) hq.push_back(1'b0);
        forever begin
            tick();
            if (!m_rst && m_en) run_meas();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (counter !== 8'(exp_cnt) || ovf !== exp_ovf || done !== exp_done) begin
                errors++;
                $display("FAIL model cyc %0d: got cnt=%0d ovf=%b done=%b want cnt=%0d ovf=%b done=%b",
                         cyc, counter, ovf, done, exp_cnt, exp_ovf, exp_done);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no strobe want strobe within %0d cycles", budget);
    endtask

    initial begin : stim
        int ta, tb, nd, act;
        rst = 1'b1; en = 1'b0; win = 16'd64;
        ro_mode = 1; ro_per = 8;
        @(negedge clk);
        chk_on = 1;
        repeat (2) @(negedge clk);
        chk("reset_cnt", 32'(counter), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_done", 32'(done), 0);
        rst = 1'b0;

        // Period 8, window 64: 8 edges, strobe one cycle wide, fixed repeat period
        en = 1'b1;
        wait_done(400 * NSUB, ta);
        chk("t1_cnt", 32'(counter), 8);
        chk("t1_ovf", 32'(ovf), 0);
        @(negedge clk);
        chk("t1_done_width", 32'(done), 0);
        wait_done(400 * NSUB, tb);
        chk("t1_period", 32'(tb - ta), 32'(64 * NSUB + GAP + S + 2));

        // Fastest toggle saturates; then period 16 over 160 gives 10
        win = 16'd1000; ro_per = 2;
        wait_done(1100 * NSUB, ta);
        chk("t2_sat_cnt", 32'(counter), 255);
        chk("t2_sat_ovf", 32'(ovf), 1);
        win = 16'd160; ro_per = 16;
        wait_done(200 * NSUB, ta);
        chk("t2_cnt", 32'(counter), 10);
        chk("t2_ovf", 32'(ovf), 0);

        // Abort 30 cycles into a window: no strobe, result held, restart gives 8
        win = 16'd64; ro_per = 8;
        wait_done(400 * NSUB, ta);
        chk("t3_pre_cnt", 32'(counter), 8);
        repeat (8 + 30) @(negedge clk);
        en = 1'b0;
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("t3_no_done", 32'(nd), 0);
        chk("t3_hold_cnt", 32'(counter), 8);
        en = 1'b1;
        wait_done(400 * NSUB, ta);
        chk("t3_resume_cnt", 32'(counter), 8);

        // Window 0 acts as 1 with RO idle
        win = 16'd0; ro_mode = 0;
        wait_done(100, ta);
        wait_done(100, tb);
        chk("t4_period", 32'(tb - ta), 32'(NSUB + GAP + S + 2));
        chk("t4_cnt", 32'(counter), 0);

        // Reset pulse mid-window clears everything, then normal operation resumes
        win = 16'd64; ro_mode = 1; ro_per = 8;
        wait_done(100, ta);
        wait_done(400 * NSUB, ta);
        chk("t5_pre_cnt", 32'(counter), 8);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_cnt", 32'(counter), 0);
        chk("t5_rst_ovf", 32'(ovf), 0);
        chk("t5_rst_done", 32'(done), 0);
        wait_done(400 * NSUB, ta);
        chk("t5_after_cnt", 32'(counter), 8);

        // Random windows, RO patterns, enable drops and resets, all against the model
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 9);
            if (act < 3) begin
                en      = 1'b0;
                win     = 16'($urandom_range(0, 40));
                ro_mode = $urandom_range(0, 2);
                ro_per  = $urandom_range(2, 12);
                repeat ($urandom_range(1, 5)) @(negedge clk);
                en = 1'b1;
            end else if (act == 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                repeat ($urandom_range(1, 120)) @(negedge clk);
            end
        end
        en = 1'b0;
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
